// File: rtl/sblk_pkg.sv
// sblk_pkg: shared types and constants for the superblock activation distributor.
package sblk_pkg;
  localparam int N_TILE_DEF      = 40;
  localparam int WID_N_TILE_DEF  = $clog2(N_TILE_DEF);
  localparam int WID_ACT_DEF     = 16;
  localparam int N_LANE_DEF      = 2;
  localparam int WID_ACTADDR_DEF = 6;
  localparam int WID_NFILL_DEF   = 8;
  localparam int BANK_BIT        = WID_ACTADDR_DEF - 1;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} state_t;
  typedef struct packed {
    logic [WID_N_TILE_DEF-1:0]    n_tile;
    logic [WID_ACTADDR_DEF-2:0]   depth;
    logic                         bcast;
    logic [WID_NFILL_DEF-1:0]     n_fill;
  } cfg_t;
endpackage

// File: rtl/sblk_act_addr_gen.sv
// sblk_act_addr_gen: tile/entry walk over one bank, last-beat detect and write-enable decode.
module sblk_act_addr_gen
  import sblk_pkg::*;
#(
  parameter int N_TILE = N_TILE_DEF
) (
  input  logic                         clk_l,
  input  logic                         rst_n,
  input  logic                         i_clr,
  input  logic                         i_adv,
  input  cfg_t                         i_cfg,
  output logic [WID_ACTADDR_DEF-2:0]   o_entry,
  output logic                         o_last,
  output logic [N_TILE-1:0]            o_en
);
  logic [WID_N_TILE_DEF-1:0]  r_tile;
  logic [WID_ACTADDR_DEF-2:0] r_entry;
  logic                       w_tile_wrap;
  // broadcast covers every tile in one beat, so the tile loop always wraps
  assign w_tile_wrap = i_cfg.bcast || (r_tile == i_cfg.n_tile);
  assign o_last      = w_tile_wrap && (r_entry == i_cfg.depth);
  assign o_entry     = r_entry;
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_tile  <= '0;
      r_entry <= '0;
    end else if (i_clr) begin
      r_tile  <= '0;
      r_entry <= '0;
    end else if (i_adv) begin
      r_tile  <= w_tile_wrap ? '0 : r_tile + 1'b1;
      r_entry <= !w_tile_wrap ? r_entry : (o_last ? '0 : r_entry + 1'b1);
    end
  end
  always_comb begin
    o_en = '0;
    for (int i = 0; i < N_TILE; i++)
      o_en[i] = i_cfg.bcast ? (i <= int'(i_cfg.n_tile)) : (i == int'(r_tile));
  end
endmodule

// File: rtl/sblk_act_dist.sv
// sblk_act_dist: streams activation beats into ping-pong tile buffer banks,
// handing each filled bank to compute and stalling until it is released.
module sblk_act_dist
  import sblk_pkg::*;
#(
  parameter int N_TILE      = N_TILE_DEF,
  parameter int WID_N_TILE  = WID_N_TILE_DEF,
  parameter int WID_ACT     = WID_ACT_DEF,
  parameter int N_LANE      = N_LANE_DEF,
  parameter int WID_ACTADDR = WID_ACTADDR_DEF,
  parameter int WID_NFILL   = WID_NFILL_DEF
) (
  input  logic                      clk_l,
  input  logic                      rst_n,
  input  logic                      cfg_vld,
  input  logic [WID_N_TILE-1:0]     cfg_n_tile,
  input  logic [WID_ACTADDR-2:0]    cfg_depth,
  input  logic                      cfg_bcast,
  input  logic [WID_NFILL-1:0]      cfg_n_fill,
  input  logic [N_LANE*WID_ACT-1:0] act_in_data,
  input  logic                      act_in_vld,
  output logic                      act_in_rdy,
  output logic [N_TILE-1:0]         act_wr_en,
  output logic [WID_ACTADDR-1:0]    act_wr_addr,
  output logic [N_LANE*WID_ACT-1:0] act_wr_data,
  output logic [1:0]                bank_full,
  input  logic [1:0]                bank_rel,
  output logic                      busy
);
  state_t                    r_state;
  cfg_t                      r_cfg;
  logic                      r_bank;
  logic [1:0]                r_full;
  logic [WID_NFILL-1:0]      r_nfill;
  logic [N_TILE-1:0]         r_wr_en;
  logic [WID_ACTADDR-1:0]    r_wr_addr;
  logic [N_LANE*WID_ACT-1:0] r_wr_data;
  logic                      w_acc, w_clr, w_last;
  logic [WID_ACTADDR-2:0]    w_entry;
  logic [N_TILE-1:0]         w_en;
  logic [WID_N_TILE-1:0]     w_n_tile;
  logic [WID_ACTADDR-1:0]    w_addr;
  logic [1:0]                w_set, w_full_nxt;
  assign act_in_rdy  = (r_state == S_FILL);
  assign busy        = (r_state != S_IDLE);
  assign act_wr_en   = r_wr_en;
  assign act_wr_addr = r_wr_addr;
  assign act_wr_data = r_wr_data;
  assign bank_full   = r_full;
  assign w_acc       = act_in_vld && act_in_rdy;
  assign w_clr       = (r_state == S_IDLE) && cfg_vld;
  assign w_n_tile    = (int'(cfg_n_tile) >= N_TILE) ? WID_N_TILE'(N_TILE - 1) : cfg_n_tile;
  // a set on the bank being released wins over the release
  assign w_set       = {2{w_acc && w_last}} & (r_bank ? 2'b10 : 2'b01);
  assign w_full_nxt  = w_set | (r_full & ~bank_rel);
  always_comb begin
    w_addr           = WID_ACTADDR'(w_entry);
    w_addr[BANK_BIT] = r_bank;
  end
  sblk_act_addr_gen #(.N_TILE(N_TILE)) u_addr_gen (
    .clk_l   (clk_l),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_adv   (w_acc),
    .i_cfg   (r_cfg),
    .o_entry (w_entry),
    .o_last  (w_last),
    .o_en    (w_en)
  );
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cfg     <= '0;
      r_bank    <= 1'b0;
      r_full    <= '0;
      r_nfill   <= '0;
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_full  <= w_full_nxt;
      r_wr_en <= w_acc ? w_en : '0;
      if (w_acc) begin
        r_wr_addr <= w_addr;
        r_wr_data <= act_in_data;
      end
      case (r_state)
        S_IDLE: if (cfg_vld) begin
          r_cfg   <= '{n_tile: w_n_tile, depth: cfg_depth, bcast: cfg_bcast, n_fill: cfg_n_fill};
          r_nfill <= '0;
          r_state <= r_full[r_bank] ? S_WAIT : S_FILL;
        end
        S_FILL: if (w_acc && w_last) begin
          r_bank  <= ~r_bank;
          r_nfill <= r_nfill + 1'b1;
          r_state <= (r_nfill == r_cfg.n_fill) ? S_IDLE : (r_full[~r_bank] ? S_WAIT : S_FILL);
        end
        // also leave WAIT if the bank was freed while entering it
        S_WAIT: if (bank_rel[r_bank] || !r_full[r_bank]) r_state <= S_FILL;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
